// File: rtl/crossbar_hs_reg_if.sv
// Flow-controlled port bundle for crossbar_hs_reg: N input ports, N output ports, per-output selects.
// The master modport is the traffic side (sources, downstream, control); slave is the crossbar itself.
interface crossbar_hs_reg_if #(
  parameter int N = 5,
  parameter int W = 8
) ();

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*N-1:0] sel;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [N-1:0]   sel_err;
  logic           err_clr;

  modport master (
    output in_data, in_valid, sel, out_ready, err_clr,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready, err_clr,
    output in_ready, out_data, out_valid, sel_err
  );

endinterface

// File: rtl/crossbar_hs_reg.sv
// NxN registered crossbar with valid/ready per port, all-or-nothing multicast and sticky select errors.
// Optional per-output accepted-flit counters are built when XBAR_FLIT_CNT_EN is defined.
module crossbar_hs_reg #(
  parameter int N = 5,
  parameter int W = 8
`ifdef XBAR_FLIT_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic              clk,
  input logic              rst,
  crossbar_hs_reg_if.slave bus
`ifdef XBAR_FLIT_CNT_EN
  , output logic [N*CNT_W-1:0] flit_cnt
`endif
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0]   legal;
  logic [N-1:0]   multi;
  logic [N-1:0]   can_load;
  logic [N-1:0]   req;
  logic [N-1:0]   load;
  logic [N-1:0]   in_ready_c;
  logic [N*W-1:0] mux_data;

  logic [N-1:0]   out_valid_q;
  logic [N*W-1:0] out_data_q;
  logic [N-1:0]   sel_err_q;

  // s & (s-1) clears the lowest set bit, so a nonzero remainder means multi-hot
  always_comb begin : decode
    logic [N-1:0] s;
    logic [N-1:0] s_low;
    s        = '0;
    s_low    = '0;
    legal    = '0;
    multi    = '0;
    req      = '0;
    mux_data = '0;
    can_load = ~out_valid_q | bus.out_ready;
    for (int j = 0; j < N; j++) begin
      s        = bus.sel[j*N +: N];
      s_low    = s & (s - ONE);
      legal[j] = (s != '0) && (s_low == '0);
      multi[j] = (s_low != '0);
      req[j]   = legal[j] && ((s & bus.in_valid) != '0);
      for (int i = 0; i < N; i++) begin
        if (s[i]) mux_data[j*W +: W] = mux_data[j*W +: W] | bus.in_data[i*W +: W];
      end
    end
  end

  // An input is taken only if every legal output selecting it can load this cycle
  always_comb begin : ready_gen
    logic any_user;
    logic blocked;
    any_user   = 1'b0;
    blocked    = 1'b0;
    in_ready_c = '0;
    for (int i = 0; i < N; i++) begin
      any_user = 1'b0;
      blocked  = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (legal[j] && bus.sel[j*N + i]) begin
          any_user = 1'b1;
          if (!can_load[j]) blocked = 1'b1;
        end
      end
      in_ready_c[i] = any_user & ~blocked;
    end
  end

  always_comb begin
    load = '0;
    for (int j = 0; j < N; j++) begin
      load[j] = req[j] && ((bus.sel[j*N +: N] & in_ready_c) != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      sel_err_q   <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (load[j]) begin
          out_data_q[j*W +: W] <= mux_data[j*W +: W];
          out_valid_q[j]       <= 1'b1;
        end else if (out_valid_q[j] && bus.out_ready[j]) begin
          out_valid_q[j] <= 1'b0;
        end
      end
      // a new error in the same cycle as err_clr survives the clear
      sel_err_q <= (bus.err_clr ? '0 : sel_err_q) | multi;
    end
  end

`ifdef XBAR_FLIT_CNT_EN
  logic [N*CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (out_valid_q[j] && bus.out_ready[j]) begin
          cnt_q[j*CNT_W +: CNT_W] <= cnt_q[j*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign flit_cnt = cnt_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_crossbar_hs_reg.sv
// Self-checking bench for crossbar_hs_reg: directed vector table, reset corner case, and random traffic
// against a port-level reference model (plus the flit counter wrap when XBAR_FLIT_CNT_EN is defined).
module tb_crossbar_hs_reg;

  localparam int N = 5;
  localparam int W = 8;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  crossbar_hs_reg_if #(.N(N), .W(W)) bus ();

`ifdef XBAR_FLIT_CNT_EN
  logic [N*CW-1:0] flit_cnt;
  crossbar_hs_reg #(.N(N), .W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .flit_cnt(flit_cnt)
  );
`else
  crossbar_hs_reg #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] sel;
    logic [4:0]  in_valid;
    logic [39:0] in_data;
    logic [4:0]  out_ready;
    logic        err_clr;
    logic [4:0]  exp_ready;
    logic [4:0]  exp_valid;
    logic [39:0] exp_data;
    logic [4:0]  exp_err;
  } vec_t;

  vec_t vecs[17];

  // reference model state, one entry per output port
  bit          m_valid[N];
  logic [7:0]  m_data[N];
  bit          m_err[N];
  int          m_cnt[N];
  logic [4:0]  m_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [24:0] s, input logic [4:0] iv, input logic [39:0] d,
                       input logic [4:0] r, input logic c);
    bus.sel       = s;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.err_clr   = c;
  endtask

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_valid[j] = 0;
      m_data[j]  = '0;
      m_err[j]   = 0;
      m_cnt[j]   = 0;
    end
  endtask

  // which input each output wants, or -1 for idle/illegal
  task automatic model_src(output int src[N], output bit bad[N]);
    logic [4:0] s;
    for (int j = 0; j < N; j++) begin
      s      = bus.sel[j*N +: N];
      src[j] = -1;
      bad[j] = ($countones(s) > 1);
      if ($countones(s) == 1)
        for (int i = 0; i < N; i++) if (s[i]) src[j] = i;
    end
  endtask

  task automatic model_ready();
    int src[N];
    bit bad[N];
    int users;
    bit ok;
    model_src(src, bad);
    for (int i = 0; i < N; i++) begin
      users = 0;
      ok    = 1;
      for (int j = 0; j < N; j++) begin
        if (src[j] == i) begin
          users++;
          if (m_valid[j] && !bus.out_ready[j]) ok = 0;
        end
      end
      m_ready[i] = (users > 0) && ok;
    end
  endtask

  task automatic model_clock();
    int src[N];
    bit bad[N];
    model_src(src, bad);
    model_ready();
    for (int j = 0; j < N; j++) begin
      if (m_valid[j] && bus.out_ready[j]) m_cnt[j] = (m_cnt[j] + 1) % (1 << CW);
      if (src[j] >= 0 && bus.in_valid[src[j]] && m_ready[src[j]]) begin
        m_data[j]  = bus.in_data[src[j]*W +: W];
        m_valid[j] = 1;
      end else if (m_valid[j] && bus.out_ready[j]) begin
        m_valid[j] = 0;
      end
      m_err[j] = bad[j] || (m_err[j] && !bus.err_clr);
    end
  endtask

  task automatic check_model(input string tag);
    logic [4:0]  ev;
    logic [39:0] ed;
    logic [4:0]  ee;
    for (int j = 0; j < N; j++) begin
      ev[j]         = m_valid[j];
      ed[j*W +: W]  = m_data[j];
      ee[j]         = m_err[j];
    end
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'(ev));
    check({tag, " out_data"},  64'(bus.out_data),  64'(ed));
    check({tag, " sel_err"},   64'(bus.sel_err),   64'(ee));
`ifdef XBAR_FLIT_CNT_EN
    begin
      logic [N*CW-1:0] ec;
      for (int j = 0; j < N; j++) ec[j*CW +: CW] = CW'(m_cnt[j]);
      check({tag, " flit_cnt"}, 64'(flit_cnt), 64'(ec));
    end
`endif
  endtask

  initial begin
    logic [24:0] rs;
    logic [4:0]  s;
    tests = 0;
    fails = 0;

    //                sel                                         in_valid  in_data          out_ready err  ready     valid     data             err
    vecs[0]  = '{{5'b0, 5'b0, 5'b0, 5'b0, 5'b00010},          5'b00010, 40'h000000A500, 5'b11111, 0, 5'b00010, 5'b00001, 40'h00000000A5, 5'b0};
    vecs[1]  = '{25'b0,                                        5'b00000, 40'h0,          5'b11111, 0, 5'b00000, 5'b00000, 40'h00000000A5, 5'b0};
    vecs[2]  = '{{5'b0, 5'b0, 5'b0, 5'b0, 5'b00001},          5'b00001, 40'h000000003C, 5'b00000, 0, 5'b00001, 5'b00001, 40'h000000003C, 5'b0};
    vecs[3]  = '{{5'b0, 5'b0, 5'b0, 5'b0, 5'b00001},          5'b00001, 40'h0000000077, 5'b00000, 0, 5'b00000, 5'b00001, 40'h000000003C, 5'b0};
    vecs[4]  = vecs[3];
    vecs[5]  = vecs[3];
    vecs[6]  = '{{5'b0, 5'b0, 5'b0, 5'b0, 5'b00001},          5'b00001, 40'h0000000077, 5'b00001, 0, 5'b00001, 5'b00001, 40'h0000000077, 5'b0};
    vecs[7]  = '{25'b0,                                        5'b00000, 40'h0,          5'b11111, 0, 5'b00000, 5'b00000, 40'h0000000077, 5'b0};
    vecs[8]  = '{{5'b0, 5'b00001, 5'b0, 5'b0, 5'b0},          5'b00001, 40'h0000000011, 5'b00000, 0, 5'b00001, 5'b01000, 40'h0011000077, 5'b0};
    vecs[9]  = '{{5'b00100, 5'b00100, 5'b0, 5'b0, 5'b00100},  5'b00100, 40'h00005A0000, 5'b00000, 0, 5'b00000, 5'b01000, 40'h0011000077, 5'b0};
    vecs[10] = '{{5'b00100, 5'b00100, 5'b0, 5'b0, 5'b00100},  5'b00100, 40'h00005A0000, 5'b01000, 0, 5'b00100, 5'b11001, 40'h5A5A00005A, 5'b0};
    vecs[11] = '{25'b0,                                        5'b00000, 40'h0,          5'b11111, 0, 5'b00000, 5'b00000, 40'h5A5A00005A, 5'b0};
    vecs[12] = '{{5'b0, 5'b0, 5'b00110, 5'b0, 5'b0},          5'b11111, 40'h9999999999, 5'b11111, 0, 5'b00000, 5'b00000, 40'h5A5A00005A, 5'b00100};
    vecs[13] = '{25'b0,                                        5'b00000, 40'h0,          5'b11111, 0, 5'b00000, 5'b00000, 40'h5A5A00005A, 5'b00100};
    vecs[14] = '{25'b0,                                        5'b00000, 40'h0,          5'b11111, 1, 5'b00000, 5'b00000, 40'h5A5A00005A, 5'b00000};
    vecs[15] = '{{5'b0, 5'b0, 5'b0, 5'b00011, 5'b0},          5'b11111, 40'h0,          5'b11111, 1, 5'b00000, 5'b00000, 40'h5A5A00005A, 5'b00010};
    vecs[16] = '{25'b0,                                        5'b00000, 40'h0,          5'b11111, 1, 5'b00000, 5'b00000, 40'h5A5A00005A, 5'b00000};

    rst = 1'b1;
    drive('0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 64'(bus.out_valid), 64'h0);
    check("reset out_data",  64'(bus.out_data),  64'h0);
    check("reset sel_err",   64'(bus.sel_err),   64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 17; k++) begin
      drive(vecs[k].sel, vecs[k].in_valid, vecs[k].in_data, vecs[k].out_ready, vecs[k].err_clr);
      #1;
      check($sformatf("vec%0d in_ready", k), 64'(bus.in_ready), 64'(vecs[k].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", k), 64'(bus.out_valid), 64'(vecs[k].exp_valid));
      check($sformatf("vec%0d out_data", k),  64'(bus.out_data),  64'(vecs[k].exp_data));
      check($sformatf("vec%0d sel_err", k),   64'(bus.sel_err),   64'(vecs[k].exp_err));
    end

    // fill every output, then reset asynchronously in the middle of the cycle
    drive({5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001}, 5'b11111, 40'h0102030405, 5'b00000, 1'b0);
    @(posedge clk);
    #1;
    check("fill out_valid", 64'(bus.out_valid), 64'h1F);
    check("fill out_data",  64'(bus.out_data),  64'h0102030405);
    rst = 1'b1;
    #1;
    check("async rst out_valid", 64'(bus.out_valid), 64'h0);
    check("async rst out_data",  64'(bus.out_data),  64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive({5'b0, 5'b0, 5'b0, 5'b0, 5'b00010}, 5'b00010, 40'h000000A500, 5'b11111, 1'b0);
    @(posedge clk);
    #1;
    check("resume out_valid", 64'(bus.out_valid), 64'h01);
    check("resume out_data",  64'(bus.out_data),  64'hA5);

    // random traffic against the reference model
    rst = 1'b1;
    drive('0, '0, '0, '0, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int j = 0; j < N; j++) begin
        case ($urandom_range(0, 9))
          0, 1:    s = 5'b0;
          9:       s = 5'b00011 << $urandom_range(0, 3);
          default: s = 5'b00001 << $urandom_range(0, 4);
        endcase
        rs[j*N +: N] = s;
      end
      drive(rs, 5'($urandom), {$urandom, 8'($urandom)}, 5'($urandom), ($urandom_range(0, 7) == 0));
      #1;
      model_ready();
      check($sformatf("rand%0d in_ready", c), 64'(bus.in_ready), 64'(m_ready));
      model_clock();
      @(posedge clk);
      #1;
      check_model($sformatf("rand%0d", c));
    end

`ifdef XBAR_FLIT_CNT_EN
    // 17 flits through output 1 with a 4-bit counter: wraps to 1
    rst = 1'b1;
    drive('0, '0, '0, '0, 1'b0);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 17; c++) begin
      drive({5'b0, 5'b0, 5'b0, 5'b00001, 5'b0}, 5'b00001, 40'(c + 1), 5'b11111, 1'b0);
      @(posedge clk);
      #1;
    end
    drive('0, '0, '0, 5'b11111, 1'b0);
    @(posedge clk);
    #1;
    check("flit_cnt wrap", 64'(flit_cnt), 64'h00010);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
